dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the MEM stage's data port (data_ce/data_we/data_addr/data write data).
//  Holds a word-addressed RAM and services one access at a time through a small FSM.
//  Reads complete after READ_LATENCY cycles. Bad accesses are flagged rather than performed.
//  stall_o holds the pipeline while an access is outstanding.
// PARAMETERS
//  DEPTH_WORDS   1024  number of 32-bit words; word index = data_addr_i[31:2]
//  READ_LATENCY  1     cycles from accept edge to read data valid; legal 1..4
// PORTS
//  clk          in   1                 clock, all state on rising edge
//  rst          in   1                 reset, asynchronous, active-low (0 = reset)
//  data_ce_i    in   1                 access request; held by requester until data_ready_o
//  data_we_i    in   1                 1 = write, 0 = read
//  data_addr_i  in   `REG_DATA_WIDTH   byte address
//  data_i       in   `REG_DATA_WIDTH   write data
//  data_sel_i   in   4                 byte-lane write strobes (only with DMEM_BYTE_WRITE_EN)
//  data_o       out  `REG_DATA_WIDTH   read data
//  data_ready_o out  1                 one-cycle completion pulse
//  data_err_o   out  1                 one-cycle error pulse, coincident with data_ready_o
//  stall_o      out  1                 hold the pipeline: data_ce_i & ~data_ready_o (combinational)
// BEHAVIOUR
//  Reset: FSM=IDLE, data_o=0, data_ready_o=0, data_err_o=0, latency counter=0. RAM contents not reset.
//  IDLE: on an edge with data_ce_i=1, latch we/addr/data and run these checks in order:
//   - misaligned (addr[1:0]!=0) or word index >= DEPTH_WORDS -> ERR; no RAM access.
//   - write -> commit to RAM at this edge -> RESP.
//   - read with READ_LATENCY=1 -> RESP, with data registered at this edge.
//   - read with READ_LATENCY>1 -> WAIT, counter=READ_LATENCY-2.
//  WAIT: counter decrements each cycle. At 0, register read data and go to RESP.
//  RESP: data_ready_o=1 for exactly one cycle, then IDLE. data_o is valid in this cycle for reads.
//  ERR: data_ready_o=1, data_err_o=1 for one cycle, data_o unchanged, then IDLE.
//  data_ce_i outside IDLE is ignored. A held request is re-accepted only in IDLE, so the earliest next accept is the cycle after RESP/ERR.
//  data_o holds the last completed read. It is only updated on read completion.
//  Latency: write and ERR respond 1 cycle after accept. A read responds READ_LATENCY cycles after accept.
//  Inputs may change while not IDLE; the latched values are used.
//  data_ce_i dropped mid-access: the access still completes and pulses ready. stall_o then reads 0.
//  Reset mid-access: an accepted write is already committed; a pending read is abandoned with no ready pulse.
//  Read-after-write to the same word on consecutive accepts returns the new data.
// CONFIGURATION
//  DMEM_BYTE_WRITE_EN defined:
//   - data_sel_i exists; write updates only lanes whose strobe is 1; lane k = bits [8k+7:8k].
//   - sel=0000 -> write completes with no RAM change.
//  DMEM_BYTE_WRITE_EN undefined: port absent; every write updates all 32 bits.
// STRUCTURE
//  Shared package (riscv_def.v): `REG_DATA_WIDTH (existing); `DMEM_ST_IDLE/WAIT/RESP/ERR 2-bit state codes.
//  Sub-module dmem_array: synchronous write with optional byte strobes, registered read, parameterised by DEPTH_WORDS.
//  The FSM, counter, address checks and stall logic live in dmem_responder.
// TESTING
//  1. Write 0xDEADBEEF @0x10, then read @0x10 (LAT=1): stall_o=1 during the access, ready 1 cycle after each accept, data_o=0xDEADBEEF.
//  2. LAT=3, read @0x20 holding 0x12345678: ready exactly 3 cycles after accept; stall_o high for those 3 cycles, low in the ready cycle.
//  3. Read @0x13, then write @(DEPTH_WORDS*4): each gives ready+err together, RAM unchanged, data_o unchanged.
//  4. BYTE_WRITE_EN: word=0x11223344, write 0xAABBCCDD with sel=0101 -> readback 0x11BB33DD.
//  5. Drop rst mid-WAIT (LAT=4): outputs 0 immediately, no ready pulse; the next read after release behaves normally.
//  6. Back-to-back writes @0x0 (0x1) then @0x0 (0x2) with data_ce_i held, then read: second accept occurs the cycle after first RESP; data_o=0x2.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared widths, FSM state codes and address check for the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

    localparam int c_REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10,
        ST_ERR  = 2'b11
    } dmem_state_t;

    // A legal access is word aligned and lands inside the array.
    function automatic logic addr_valid(
        input logic [c_REG_DATA_WIDTH-1:0] addr,
        input int unsigned                 depth_words
    );
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth_words);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module      : dmem_array
// Description : Word-addressed RAM with per-lane synchronous write and a
//               registered, enable-gated read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [3:0]                  be,
    input  logic [IDX_W-1:0]            waddr,
    input  logic [c_REG_DATA_WIDTH-1:0] wdata,
    input  logic                        re,
    input  logic [IDX_W-1:0]            raddr,
    output logic [c_REG_DATA_WIDTH-1:0] rdata
);

    logic [c_REG_DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [c_REG_DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    r_mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // The read register holds its value between reads so the last completed
    // read stays visible on the responder output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage data-port responder: one access at a time, reads
//               after READ_LATENCY cycles, bad addresses flagged as errors.
//               Optional byte-lane writes via macro DMEM_BYTE_WRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_ce_i,
    input  logic                        data_we_i,
    input  logic [c_REG_DATA_WIDTH-1:0] data_addr_i,
    input  logic [c_REG_DATA_WIDTH-1:0] data_i,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]                  data_sel_i,
`endif
    output logic [c_REG_DATA_WIDTH-1:0] data_o,
    output logic                        data_ready_o,
    output logic                        data_err_o,
    output logic                        stall_o
);

    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_WAIT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    dmem_state_t        r_state;
    dmem_state_t        w_state_nxt;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_req_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_addr_ok;
    logic               w_accept;
    logic               w_mem_we;
    logic               w_mem_re;
    logic [3:0]         w_sel;

`ifdef DMEM_BYTE_WRITE_EN
    assign w_sel = data_sel_i;
`else
    assign w_sel = 4'hF;
`endif

    assign w_req_idx = data_addr_i[c_IDX_W+1:2];
    assign w_addr_ok = addr_valid(data_addr_i, DEPTH_WORDS);
    assign w_accept  = (r_state == ST_IDLE) && data_ce_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx <= w_req_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_rd_idx    = r_idx;
        case (r_state)
            ST_IDLE: begin
                // Single-cycle reads sample the live address at the accept edge.
                w_rd_idx = w_req_idx;
                if (data_ce_i) begin
                    if (!w_addr_ok) begin
                        w_state_nxt = ST_ERR;
                    end else if (data_we_i) begin
                        w_mem_we    = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else if (READ_LATENCY == 1) begin
                        w_mem_re    = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = c_WAIT_INIT;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_mem_re    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (w_mem_we),
        .be    (w_sel),
        .waddr (w_req_idx),
        .wdata (data_i),
        .re    (w_mem_re),
        .raddr (w_rd_idx),
        .rdata (data_o)
    );

    assign data_ready_o = (r_state == ST_RESP) || (r_state == ST_ERR);
    assign data_err_o   = (r_state == ST_ERR);
    assign stall_o      = data_ce_i & ~data_ready_o;

endmodule

`default_nettype wire
